// File: rtl/ack_pkg.sv
// Shared codes, frame constants and FSM encoding for the command reply packer.
package ack_pkg;

  localparam int unsigned CODE_W = 6;
  localparam int unsigned IDX_W  = 3;

  // Parser state codes
  localparam logic [CODE_W-1:0] ST_FREE        = 6'h00;
  localparam logic [CODE_W-1:0] ST_CHECK       = 6'h01;
  localparam logic [CODE_W-1:0] ST_CONFIG      = 6'h02;
  localparam logic [CODE_W-1:0] ST_START       = 6'h04;
  localparam logic [CODE_W-1:0] ST_STOP        = 6'h08;
  localparam logic [CODE_W-1:0] ST_CALIBRATION = 6'h10;
  localparam logic [CODE_W-1:0] ST_STOP_CALI   = 6'h20;
  localparam logic [CODE_W-1:0] ST_TRIGGER_OUT = 6'h21;

  // Host command codes
  localparam logic [15:0] CMD_CHECK       = 16'h0001;
  localparam logic [15:0] CMD_CONFIG      = 16'h0002;
  localparam logic [15:0] CMD_START       = 16'h0003;
  localparam logic [15:0] CMD_STOP        = 16'h0004;
  localparam logic [15:0] CMD_CALIBRATION = 16'h0005;
  localparam logic [15:0] CMD_STOP_CALI   = 16'h0006;
  localparam logic [15:0] CMD_TRIGGER_OUT = 16'h0105;
  localparam logic [15:0] REPLY_BIT       = 16'h8000;

  localparam logic [7:0] HDR_BYTE  = 8'h3A;
  localparam logic [7:0] TAIL_BYTE = 8'h0A;

  // Payload byte counts
  localparam logic [IDX_W-1:0] LEN_CHECK  = 3'd4;
  localparam logic [IDX_W-1:0] LEN_CONFIG = 3'd5;
  localparam logic [IDX_W-1:0] LEN_SHORT  = 3'd1;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_LEN, S_CMD, S_PAY, S_CSUM, S_TAIL, S_DONE, S_WAIT_FREE
  } fsm_e;

  // Configuration snapshot taken when a command is captured
  typedef struct packed {
    logic [7:0]  laser;
    logic [7:0]  samp;
    logic [7:0]  freq;
    logic [15:0] rate;
    logic [7:0]  trig;
  } cfg_t;

  // True for every code that produces a reply
  function automatic logic is_known(input logic [CODE_W-1:0] code);
    case (code)
      ST_CHECK, ST_CONFIG, ST_START, ST_STOP,
      ST_CALIBRATION, ST_STOP_CALI, ST_TRIGGER_OUT: is_known = 1'b1;
      default:                                      is_known = 1'b0;
    endcase
  endfunction

  // Request command word for a parser state code
  function automatic logic [15:0] cmd_of(input logic [CODE_W-1:0] code);
    case (code)
      ST_CHECK:       cmd_of = CMD_CHECK;
      ST_CONFIG:      cmd_of = CMD_CONFIG;
      ST_START:       cmd_of = CMD_START;
      ST_STOP:        cmd_of = CMD_STOP;
      ST_CALIBRATION: cmd_of = CMD_CALIBRATION;
      ST_STOP_CALI:   cmd_of = CMD_STOP_CALI;
      ST_TRIGGER_OUT: cmd_of = CMD_TRIGGER_OUT;
      default:        cmd_of = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/ack_payload_mux.sv
// Payload byte and payload length lookup for a captured command.
module ack_payload_mux import ack_pkg::*; #(
  parameter logic [7:0] FW_VERSION = 8'h12
) (
  input  logic [CODE_W-1:0] code_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  cfg_t              cfg_i,
  output logic [7:0]        byte_o,
  output logic [IDX_W-1:0]  len_o
);

  // Select payload byte idx_i of the reply for code_i
  always_comb begin
    byte_o = 8'h00;
    len_o  = '0;
    case (code_i)
      ST_CHECK: begin
        len_o = LEN_CHECK;
        case (idx_i)
          3'd0:    byte_o = cfg_i.laser;
          3'd1:    byte_o = cfg_i.samp;
          3'd2:    byte_o = cfg_i.freq;
          3'd3:    byte_o = FW_VERSION;
          default: byte_o = 8'h00;
        endcase
      end
      ST_CONFIG: begin
        len_o = LEN_CONFIG;
        case (idx_i)
          3'd0:    byte_o = cfg_i.laser;
          3'd1:    byte_o = cfg_i.samp;
          3'd2:    byte_o = cfg_i.freq;
          3'd3:    byte_o = cfg_i.rate[7:0];
          3'd4:    byte_o = cfg_i.rate[15:8];
          default: byte_o = 8'h00;
        endcase
      end
      ST_TRIGGER_OUT: begin
        len_o  = LEN_SHORT;
        byte_o = cfg_i.trig;
      end
      ST_START, ST_STOP, ST_CALIBRATION, ST_STOP_CALI: begin
        len_o  = LEN_SHORT;
        byte_o = 8'h00;
      end
      default: begin
        len_o  = '0;
        byte_o = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/cmd_ack_packer.sv
// Reply framer: captures a parser command and streams 3A/LEN/CMD/payload/CSUM/0A
// into the TX FIFO, then pulses state_flag. Optional stall timeout abort is
// enabled with the ACK_TX_TIMEOUT_EN macro.
module cmd_ack_packer import ack_pkg::*; #(
  parameter logic [7:0]  FW_VERSION     = 8'h12,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  state,
  input  logic [7:0]  laser_channel_data,
  input  logic [7:0]  sampling_channel_data,
  input  logic [7:0]  sampling_frequency_data,
  input  logic [15:0] channel_samp_frequency,
  input  logic [7:0]  trigger_out_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        state_flag,
  output logic        busy,
  output logic        tx_err
);

  // A zero limit would abort every stalled byte immediately
  if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("cmd_ack_packer: TIMEOUT_CYCLES must be non-zero");
  end

  fsm_e              fsm_q, fsm_d;
  logic [CODE_W-1:0] code_q, code_d;
  cfg_t              cfg_q, cfg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              state_flag_q, state_flag_d;
  logic              busy_q, busy_d;

  logic              accept_c;
  logic [IDX_W-1:0]  pay_idx_c;
  logic [7:0]        pay_byte_c;
  logic [IDX_W-1:0]  pay_len_c;
  logic [7:0]        sum_next_c;
  logic [15:0]       rcmd_c;

`ifdef ACK_TX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            tx_err_q, tx_err_d;
`endif

  assign accept_c   = tx_valid_q && tx_ready;
  assign sum_next_c = sum_q + tx_data_q;
  assign rcmd_c     = cmd_of(code_q) | REPLY_BIT;
  // Index of the payload byte to be loaded on the next accept
  assign pay_idx_c  = (fsm_q == S_PAY) ? idx_q + IDX_W'(1) : '0;

  ack_payload_mux #(.FW_VERSION(FW_VERSION)) u_pay (
    .code_i (code_q),
    .idx_i  (pay_idx_c),
    .cfg_i  (cfg_q),
    .byte_o (pay_byte_c),
    .len_o  (pay_len_c)
  );

  // Next-state, next output byte and checksum accumulation
  always_comb begin
    fsm_d        = fsm_q;
    code_d       = code_q;
    cfg_d        = cfg_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    state_flag_d = 1'b0;
    busy_d       = busy_q;
`ifdef ACK_TX_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    tx_err_d     = 1'b0;
`endif

    unique case (fsm_q)
      S_IDLE: begin
        if (is_known(state)) begin
          fsm_d  = S_HDR;
          code_d = state;
          cfg_d  = '{laser: laser_channel_data, samp: sampling_channel_data,
                     freq: sampling_frequency_data, rate: channel_samp_frequency,
                     trig: trigger_out_data};
          idx_d  = '0;
          sum_d  = '0;
          busy_d = 1'b1;
        end
      end
      S_HDR: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = HDR_BYTE;
        end else if (accept_c) begin
          fsm_d     = S_LEN;
          idx_d     = '0;
          sum_d     = sum_next_c;
          tx_data_d = 8'(pay_len_c);
        end
      end
      S_LEN: begin
        if (accept_c) begin
          sum_d = sum_next_c;
          if (idx_q == IDX_W'(3)) begin
            fsm_d     = S_CMD;
            idx_d     = '0;
            tx_data_d = rcmd_c[7:0];
          end else begin
            // Payloads never exceed 255 bytes, so upper length bytes are zero
            idx_d     = idx_q + IDX_W'(1);
            tx_data_d = 8'h00;
          end
        end
      end
      S_CMD: begin
        if (accept_c) begin
          sum_d = sum_next_c;
          if (idx_q == '0) begin
            idx_d     = IDX_W'(1);
            tx_data_d = rcmd_c[15:8];
          end else begin
            fsm_d     = S_PAY;
            idx_d     = '0;
            tx_data_d = pay_byte_c;
          end
        end
      end
      S_PAY: begin
        if (accept_c) begin
          sum_d = sum_next_c;
          if (idx_q == pay_len_c - IDX_W'(1)) begin
            fsm_d     = S_CSUM;
            tx_data_d = ~sum_next_c + 8'd1;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            tx_data_d = pay_byte_c;
          end
        end
      end
      S_CSUM: begin
        if (accept_c) begin
          fsm_d     = S_TAIL;
          tx_data_d = TAIL_BYTE;
        end
      end
      S_TAIL: begin
        if (accept_c) begin
          fsm_d        = S_DONE;
          tx_valid_d   = 1'b0;
          tx_data_d    = 8'h00;
          state_flag_d = 1'b1;
        end
      end
      S_DONE: begin
        fsm_d = S_WAIT_FREE;
      end
      S_WAIT_FREE: begin
        if (state == ST_FREE) begin
          fsm_d  = S_IDLE;
          busy_d = 1'b0;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase

`ifdef ACK_TX_TIMEOUT_EN
    // Abort the frame once a byte has been stalled for TIMEOUT_CYCLES
    if (tx_valid_q && !tx_ready) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        fsm_d        = S_WAIT_FREE;
        tx_valid_d   = 1'b0;
        tx_data_d    = 8'h00;
        tx_err_d     = 1'b1;
        state_flag_d = 1'b1;
        to_cnt_d     = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= S_IDLE;
      code_q       <= '0;
      cfg_q        <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      state_flag_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ACK_TX_TIMEOUT_EN
      to_cnt_q     <= '0;
      tx_err_q     <= 1'b0;
`endif
    end else begin
      fsm_q        <= fsm_d;
      code_q       <= code_d;
      cfg_q        <= cfg_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      state_flag_q <= state_flag_d;
      busy_q       <= busy_d;
`ifdef ACK_TX_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      tx_err_q     <= tx_err_d;
`endif
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign state_flag = state_flag_q;
  assign busy       = busy_q;
`ifdef ACK_TX_TIMEOUT_EN
  assign tx_err     = tx_err_q;
`else
  assign tx_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_ack_packer.sv
// Bench for cmd_ack_packer: vector table of commands with expected frames fed
// to a byte scoreboard, plus hand sequences for reset and re-arm corners.
module tb_cmd_ack_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  state;
  logic [7:0]  laser_channel_data, sampling_channel_data, sampling_frequency_data;
  logic [15:0] channel_samp_frequency;
  logic [7:0]  trigger_out_data;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, state_flag, busy, tx_err;

  cmd_ack_packer #(.FW_VERSION(8'h12), .TIMEOUT_CYCLES(16)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .state                   (state),
    .laser_channel_data      (laser_channel_data),
    .sampling_channel_data   (sampling_channel_data),
    .sampling_frequency_data (sampling_frequency_data),
    .channel_samp_frequency  (channel_samp_frequency),
    .trigger_out_data        (trigger_out_data),
    .tx_data                 (tx_data),
    .tx_valid                (tx_valid),
    .tx_ready                (tx_ready),
    .state_flag              (state_flag),
    .busy                    (busy),
    .tx_err                  (tx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  code;
    logic [7:0]  laser;
    logic [7:0]  samp;
    logic [7:0]  freq;
    logic [15:0] rate;
    logic [7:0]  trig;
    int          n;
    logic [15:0] rcmd;
    logic [7:0]  csum;
    bit          stall;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  int         acc_cnt = 0;
  int         flag_cnt = 0;
  int         valid_beats = 0;
  bit         stall_chk_en = 1'b1;
  bit         abort_expected = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare each accepted byte, check stall stability and flag timing
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (stall_chk_en && prev_stall) begin
        chk("stall_valid_held", 32'(tx_valid), 32'd1);
        chk("stall_data_held", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid) valid_beats++;
      if (tx_valid && tx_ready) begin
        acc_cnt++;
        chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("frame_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (state_flag) begin
        flag_cnt++;
        if (!abort_expected) begin
          chk("flag_after_tail", 32'(exp_q.size()), 32'd0);
          chk("tx_err_quiet", 32'(tx_err), 32'd0);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic push_frame(input vec_t v);
    logic [7:0] pay [$];
    case (v.code)
      6'h01:   pay = '{v.laser, v.samp, v.freq, 8'h12};
      6'h02:   pay = '{v.laser, v.samp, v.freq, v.rate[7:0], v.rate[15:8]};
      6'h21:   pay = '{v.trig};
      default: pay = '{8'h00};
    endcase
    chk("table_len", 32'(pay.size()), 32'(v.n));
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'(v.n));
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(v.rcmd[7:0]);
    exp_q.push_back(v.rcmd[15:8]);
    foreach (pay[i]) exp_q.push_back(pay[i]);
    exp_q.push_back(v.csum);
    exp_q.push_back(8'h0A);
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    int fl0, cyc;
    bit seen;
    laser_channel_data      = v.laser;
    sampling_channel_data   = v.samp;
    sampling_frequency_data = v.freq;
    channel_samp_frequency  = v.rate;
    trigger_out_data        = v.trig;
    tx_ready                = 1'b1;
    push_frame(v);
    fl0         = flag_cnt;
    valid_beats = 0;
    state       = v.code;
    @(posedge clk); #1;
    chk("busy_at_capture", 32'(busy), 32'd1);
    chk("no_valid_at_capture", 32'(tx_valid), 32'd0);
    // Inputs change mid-packet; the captured copy must be used
    laser_channel_data      = 8'($urandom);
    sampling_channel_data   = 8'($urandom);
    sampling_frequency_data = 8'($urandom);
    channel_samp_frequency  = 16'($urandom);
    trigger_out_data        = 8'($urandom);
    cyc = 0;
    while (flag_cnt == fl0 && cyc < 200) begin
      tx_ready = v.stall ? ~tx_ready : 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        chk("start_valid", 32'(tx_valid), 32'd1);
        chk("start_hdr", 32'(tx_data), 32'h3A);
      end
    end
    tx_ready = 1'b1;
    chk("one_flag", 32'(flag_cnt - fl0), 32'd1);
    if (!v.stall) chk("frame_beats", 32'(valid_beats), 32'(9 + v.n));
    seen = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      seen |= tx_valid;
    end
    chk("no_second_frame", 32'(seen), 32'd0);
    chk("no_second_flag", 32'(flag_cnt - fl0), 32'd1);
    chk("busy_until_free", 32'(busy), 32'd1);
    state = 6'h00;
    @(posedge clk); #1;
    chk("rearm_busy_low", 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, f0, cyc, n;
    bit seen_valid;
    vec_t rv;

    //           code   laser  samp   freq   rate      trig   n  rcmd      csum   stall
    vecs[0] = '{6'h01, 8'd8,  8'd8,  8'd10, 16'd0,    8'h00, 4, 16'h8001, 8'h15, 1'b0};
    vecs[1] = '{6'h04, 8'd8,  8'd8,  8'd10, 16'd0,    8'h00, 1, 16'h8003, 8'h42, 1'b0};
    vecs[2] = '{6'h02, 8'd8,  8'd8,  8'd10, 16'hC350, 8'h00, 5, 16'h8002, 8'h12, 1'b1};
    vecs[3] = '{6'h21, 8'd8,  8'd8,  8'd10, 16'd0,    8'h5A, 1, 16'h8105, 8'hE5, 1'b0};
    vecs[4] = '{6'h08, 8'd8,  8'd8,  8'd10, 16'd0,    8'h00, 1, 16'h8004, 8'h41, 1'b0};
    vecs[5] = '{6'h08, 8'd8,  8'd8,  8'd10, 16'd0,    8'h00, 1, 16'h8004, 8'h41, 1'b0};
    vecs[6] = '{6'h10, 8'd3,  8'd4,  8'd5,  16'd0,    8'h00, 1, 16'h8005, 8'h40, 1'b0};
    vecs[7] = '{6'h20, 8'd3,  8'd4,  8'd5,  16'd0,    8'h00, 1, 16'h8006, 8'h3F, 1'b1};
    vecs[8] = '{6'h01, 8'hFF, 8'h80, 8'h01, 16'd0,    8'h00, 4, 16'h8001, 8'hAF, 1'b0};

    rst = 1'b1; state = 6'h00; tx_ready = 1'b0;
    laser_channel_data = 8'h00; sampling_channel_data = 8'h00;
    sampling_frequency_data = 8'h00; channel_samp_frequency = 16'h0000;
    trigger_out_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_state_flag", 32'(state_flag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_err", 32'(tx_err), 32'd0);
    rst = 1'b0;

    // Unrecognised code is ignored
    state = 6'h03;
    repeat (5) @(posedge clk);
    #1;
    chk("unknown_busy", 32'(busy), 32'd0);
    chk("unknown_valid", 32'(tx_valid), 32'd0);
    state = 6'h00;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], 20);

    // Reset during LEN abandons the frame
    rv = vecs[0];
    laser_channel_data = rv.laser; sampling_channel_data = rv.samp;
    sampling_frequency_data = rv.freq;
    tx_ready = 1'b1;
    push_frame(rv);
    a0 = acc_cnt; f0 = flag_cnt;
    state = rv.code;
    cyc = 0;
    while (acc_cnt < a0 + 2 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reached_len", 32'(acc_cnt - a0), 32'd2);
    rst = 1'b1; state = 6'h00;
    @(posedge clk); #1;
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_state_flag", 32'(state_flag), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tx_err", 32'(tx_err), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_flag", 32'(flag_cnt - f0), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

`ifdef ACK_TX_TIMEOUT_EN
    // Permanent back-pressure aborts the frame after the limit
    stall_chk_en = 1'b0; abort_expected = 1'b1;
    tx_ready = 1'b0; state = 6'h04;
    @(posedge clk); #1;
    cyc = 0; n = 0; seen_valid = 1'b0;
    while (!tx_err && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (seen_valid) n++;
      if (tx_valid) seen_valid = 1'b1;
    end
    chk("timeout_stalled_cycles", 32'(n), 32'd16);
    chk("timeout_err", 32'(tx_err), 32'd1);
    chk("timeout_flag", 32'(state_flag), 32'd1);
    chk("timeout_valid_drop", 32'(tx_valid), 32'd0);
    @(posedge clk); #1;
    chk("timeout_err_pulse", 32'(tx_err), 32'd0);
    chk("timeout_flag_pulse", 32'(state_flag), 32'd0);
    chk("timeout_wait_free", 32'(busy), 32'd1);
    state = 6'h00; tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("timeout_rearm", 32'(busy), 32'd0);
    stall_chk_en = 1'b1; abort_expected = 1'b0;
`else
    n = 0; seen_valid = 1'b0;
`endif

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_ack_packer.md
# cmd_ack_packer

Builds the reply packet for each host command. It sits directly downstream of the command parser and consumes its `state` code and configuration registers. For each accepted command it streams a framed reply (header, length, command, payload, checksum, tail) into the FT232 transmit FIFO. When the last byte is accepted it pulses `state_flag`, which returns the parser to its idle state.

## Interface
- `FW_VERSION`, 8'h12: firmware version byte returned in the CHECK reply.
- `TIMEOUT_CYCLES`, 50000: back-pressure limit. Used only when `ACK_TX_TIMEOUT_EN` is defined.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `state` in 6: command state code from the parser.
- `laser_channel_data` in 8: current light-source channel count.
- `sampling_channel_data` in 8: current detector channel count.
- `sampling_frequency_data` in 8: current light-source switch frequency.
- `channel_samp_frequency` in 16: current ADC sample rate.
- `trigger_out_data` in 8: current trigger-output byte.
- `tx_data` out 8: reply byte to the TX FIFO.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: TX FIFO can accept a byte (not full).
- `state_flag` out 1: one-cycle pulse when a reply is finished.
- `busy` out 1: high from capture until re-arm.
- `tx_err` out 1: one-cycle pulse on timeout abort (constant 0 when `ACK_TX_TIMEOUT_EN` is not defined).

## Operation
- **State codes:** FREE 0x00, CHECK 0x01, CONFIG 0x02, START 0x04, STOP 0x08, CALIBRATION 0x10, STOP_CALI 0x20, TRIGGER_OUT 0x21.
- **Command codes:** CHECK 0x0001, CONFIG 0x0002, START 0x0003, STOP 0x0004, CALIBRATION 0x0005, STOP_CALI 0x0006, TRIGGER_OUT 0x0105.
- **Reply command:** request command OR 0x8000.
- **Frame layout:** 0x3A, LEN (4 bytes, little-endian payload count), CMD (2 bytes, little-endian), payload, CSUM, 0x0A.
- **Checksum:** CSUM = (~S + 1) mod 256, where S is the 8-bit wrapping sum of every byte from 0x3A through the last payload byte.
- **Payloads:**
  - CHECK: laser, samp, freq, `FW_VERSION` (4 bytes).
  - CONFIG: laser, samp, freq, rate[7:0], rate[15:8] (5 bytes).
  - START, STOP, CALIBRATION, STOP_CALI: one byte, 0x00.
  - TRIGGER_OUT: one byte, `trigger_out_data`.
- **Capture:** in IDLE, a recognised non-FREE code is captured, together with all configuration inputs. Unrecognised codes are ignored and the FSM stays in IDLE.
- **FSM:** IDLE → HDR → LEN(4) → CMD(2) → PAY(n) → CSUM → TAIL → DONE → WAIT_FREE → IDLE.
- **Byte advance:** each byte state advances only on `tx_valid && tx_ready`.
- **DONE:** asserts `state_flag` for exactly one cycle.
- **WAIT_FREE:** holds until `state == FREE`, so one command never produces two replies.
- **Input changes mid-packet:** ignored; the captured copy is used throughout.

## Timing
- **Reset values:** `tx_data` 0, `tx_valid` 0, `state_flag` 0, `busy` 0, `tx_err` 0; FSM in IDLE; byte index, checksum and captured copy all cleared.
- **Start latency:** code captured at edge k; `tx_valid` high with 0x3A after edge k+1. `busy` is high from edge k.
- **Stall rule:** `tx_valid` and `tx_data` stay stable while `tx_ready` is low. `tx_valid` never drops before the byte is accepted.
- **Throughput:** with `tx_ready` held high, one byte per cycle; a frame is 9+n beats.
- **`state_flag`:** high the cycle after the tail byte is accepted.
- **Re-arm:** at the earliest, one cycle after `state` returns to FREE.
- **Reset mid-frame:** the frame is abandoned at once; no tail, no `state_flag`.

## Configuration
- **`ACK_TX_TIMEOUT_EN` defined:**
  - A counter runs while `tx_valid && !tx_ready`; it clears on any accept.
  - On reaching `TIMEOUT_CYCLES` the frame is aborted, `tx_valid` drops, and `tx_err` and `state_flag` pulse together in the same cycle.
  - The FSM then goes to WAIT_FREE.
- **Not defined:** the block waits indefinitely and `tx_err` is tied to 0.

## Structure
- **Package `ack_pkg`:** state codes, command codes, 0x8000 reply bit, header 0x3A, tail 0x0A, per-command payload lengths, FSM state enum.
- **Sub-module `ack_payload_mux`:** combinational map from (captured code, payload index, captured configuration) to payload byte and payload length.
- **Top level:** FSM, counters and checksum accumulator.

## Test plan
- **CHECK, defaults:** `state`=0x01, laser 8, samp 8, freq 10, `tx_ready`=1 → `3A 04 00 00 00 01 80 08 08 0A 12 15 0A`, then one `state_flag` pulse.
- **START:** `state`=0x04 → `3A 01 00 00 00 03 80 00 42 0A`.
- **CONFIG under back-pressure:** CONFIG with rate 50000 (0xC350) and `tx_ready` toggling every other cycle → payload ends `50 C3`; `tx_data` stays stable during stalls; checksum correct.
- **TRIGGER_OUT:** `state`=0x21 with `trigger_out_data`=0x5A → CMD bytes `05 81`, payload `5A`.
- **No double reply:** hold `state`=0x08 for 20 cycles after `state_flag` → no second frame; a second frame follows only after FREE then 0x08 again.
- **Reset mid-frame:** assert `rst` during LEN → all outputs 0 next cycle, no `state_flag`. With `ACK_TX_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, hold `tx_ready`=0 → `tx_err` and `state_flag` pulse after 16 stalled cycles.
